// File: rtl/cb_pkg.sv
// Shared constants and elaboration-time helpers for the connection box.
package cb_pkg;

  localparam int unsigned CFG_W        = 32;
  localparam logic [7:0]  CFG_ADDR_IDX = 8'h00;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) c += 32'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/cb_config_reg.sv
// Index-0 config register with async reset, address decode and readback mux.
module cb_config_reg
  import cb_pkg::*;
#(
  parameter int unsigned SW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CFG_W-1:0] config_addr,
  input  logic [CFG_W-1:0] config_data,
  input  logic             config_en,
  output logic [SW-1:0]    sel,
  output logic [CFG_W-1:0] read_data
);

  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic             hit;
  logic             unused_addr_lo;

  assign hit            = (config_addr[31:24] == CFG_ADDR_IDX);
  assign unused_addr_lo = ^config_addr[23:0];

  always_comb begin
    cfg_d = cfg_q;
    if (config_en && hit) cfg_d = config_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cfg_q <= '0;
    else       cfg_q <= cfg_d;
  end

  assign sel       = cfg_q[SW-1:0];
  assign read_data = hit ? cfg_q : '0;

endmodule

// File: rtl/connect_box_w7_t8.sv
// Connection box: config-selected combinational mux from routing tracks to one core input.
module connect_box_w7_t8
  import cb_pkg::*;
#(
  parameter int unsigned WIDTH               = 7,
  parameter int unsigned NUM_TRACKS          = 8,
  parameter int unsigned HAS_CONSTANT        = 0,
  parameter int unsigned DEFAULT_VALUE       = 0,
  parameter logic [7:0]  FEEDTHROUGH_OUTPUTS = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CFG_W-1:0] config_addr,
  input  logic [CFG_W-1:0] config_data,
  input  logic             config_en,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [WIDTH-1:0] in_4,
  input  logic [WIDTH-1:0] in_5,
  input  logic [WIDTH-1:0] in_6,
  input  logic [WIDTH-1:0] in_7,
  output logic [WIDTH-1:0] out,
  output logic [CFG_W-1:0] read_data
);

  localparam int unsigned N      = popcount(32'(FEEDTHROUGH_OUTPUTS));
  localparam int unsigned NI     = N + HAS_CONSTANT;
  localparam int unsigned SW_RAW = clog2(NI);
  localparam int unsigned SW     = (SW_RAW == 0) ? 1 : SW_RAW;

  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] tracks [8];
  logic [WIDTH-1:0] mux_in [NI];

  assign tracks[0] = in_0;
  assign tracks[1] = in_1;
  assign tracks[2] = in_2;
  assign tracks[3] = in_3;
  assign tracks[4] = in_4;
  assign tracks[5] = in_5;
  assign tracks[6] = in_6;
  assign tracks[7] = in_7;

  cb_config_reg #(.SW(SW)) u_cfg (
    .clk         (clk),
    .reset       (reset),
    .config_addr (config_addr),
    .config_data (config_data),
    .config_en   (config_en),
    .sel         (sel),
    .read_data   (read_data)
  );

  // Enabled track i lands at slot = number of enabled tracks below it.
  for (genvar i = 0; i < 8; i++) begin : g_trk
    if (i < NUM_TRACKS && FEEDTHROUGH_OUTPUTS[i]) begin : g_en
      assign mux_in[popcount(32'(FEEDTHROUGH_OUTPUTS) & ((32'd1 << i) - 32'd1))] = tracks[i];
    end else begin : g_off
      logic unused_trk;
      assign unused_trk = ^tracks[i];
    end
  end

  if (HAS_CONSTANT != 0) begin : g_const
    assign mux_in[N] = WIDTH'(DEFAULT_VALUE);
  end

  always_comb begin
    out = '0;
    for (int k = 0; k < int'(NI); k++) begin
      if (sel == SW'(k)) out = mux_in[k];
    end
  end

endmodule

// File: tb/tb_connect_box_w7_t8.sv
// Directed and random checks of two connection-box configurations against a list-based model.
module tb_connect_box_w7_t8;

  localparam int W = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] config_addr, config_data;
  logic        config_en;
  logic [W-1:0] in_v [8];
  logic [W-1:0] out_a, out_b;
  logic [31:0]  rd_a, rd_b;

  int checks = 0;
  int failures = 0;
  logic [31:0] cfg_m;

  always #5 clk = ~clk;

  connect_box_w7_t8 u_dut_a (
    .clk(clk), .reset(reset), .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
    .in_4(in_v[4]), .in_5(in_v[5]), .in_6(in_v[6]), .in_7(in_v[7]),
    .out(out_a), .read_data(rd_a)
  );

  connect_box_w7_t8 #(
    .HAS_CONSTANT(1), .DEFAULT_VALUE(5), .FEEDTHROUGH_OUTPUTS(8'hF5)
  ) u_dut_b (
    .clk(clk), .reset(reset), .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .in_0(in_v[0]), .in_1(in_v[1]), .in_2(in_v[2]), .in_3(in_v[3]),
    .in_4(in_v[4]), .in_5(in_v[5]), .in_6(in_v[6]), .in_7(in_v[7]),
    .out(out_b), .read_data(rd_b)
  );

  // Reference: list enabled tracks, append constant, select by low bits of cfg.
  function automatic logic [W-1:0] ref_out(input logic [7:0] mask, input int has_c,
                                            input int defv, input logic [31:0] cfg);
    logic [W-1:0] lst[$];
    int sw, sel;
    for (int i = 0; i < 8; i++) if (mask[i]) lst.push_back(in_v[i]);
    if (has_c != 0) lst.push_back(W'(defv));
    sw = $clog2(lst.size());
    if (sw == 0) sw = 1;
    sel = int'(cfg & ((32'd1 << sw) - 32'd1));
    return (sel < lst.size()) ? lst[sel] : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_rd;
    exp_rd = (config_addr[31:24] == 8'h00) ? cfg_m : 32'h0;
    chk({tag, ".rd_a"},  rd_a, exp_rd);
    chk({tag, ".rd_b"},  rd_b, exp_rd);
    chk({tag, ".out_a"}, 32'(out_a), 32'(ref_out(8'hFF, 0, 0, cfg_m)));
    chk({tag, ".out_b"}, 32'(out_b), 32'(ref_out(8'hF5, 1, 5, cfg_m)));
  endtask

  task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    config_addr = addr;
    config_data = data;
    config_en   = 1'b1;
    @(posedge clk);
    #1;
    config_en = 1'b0;
    if (addr[31:24] == 8'h00) cfg_m = data;
  endtask

  initial begin
    reset = 1'b1;
    config_en = 1'b0;
    config_addr = 32'h0;
    config_data = 32'h0;
    for (int i = 0; i < 8; i++) in_v[i] = W'(i + 16);
    cfg_m = 32'h0;
    #12;
    check_all("reset");
    chk("reset.out_in0", 32'(out_a), 32'd16);
    @(negedge clk);
    reset = 1'b0;

    in_v[1] = 7'd4;
    cfg_write(32'h0, 32'h1);
    chk("sel1.out", 32'(out_a), 32'd4);

    in_v[6] = 7'd34;
    cfg_write(32'h0, 32'h6);
    chk("sel6.out", 32'(out_a), 32'd34);

    cfg_write(32'h0, 32'h70);
    in_v[0] = 7'd1;
    #1;
    chk("hi_bits.rd", rd_a, 32'h70);
    chk("hi_bits.out", 32'(out_a), 32'd1);

    cfg_write(32'h0100_0000, 32'h3);
    chk("other_idx.rd", rd_a, 32'h0);
    config_addr = 32'h0000_1234;
    #1;
    chk("other_idx.kept", rd_a, 32'h70);
    check_all("other_idx");

    cfg_write(32'h0, 32'h1);
    chk("mask.code1", 32'(out_b), 32'(in_v[2]));
    cfg_write(32'h0, 32'h6);
    chk("mask.code6", 32'(out_b), 32'd5);
    cfg_write(32'h0, 32'h7);
    chk("mask.code7", 32'(out_b), 32'd0);
    check_all("mask");

    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < 8; i++) in_v[i] = W'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        #1;
        check_all("rnd_in");
      end else begin
        cfg_write(($urandom_range(0, 4) == 0) ? {8'($urandom_range(1, 255)), 24'($urandom)}
                                              : {8'h00, 24'($urandom)},
                  {$urandom} & ($urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h7));
        check_all("rnd_wr");
      end
    end

    // Reset asserted mid-write clears cfg without waiting for an edge.
    config_addr = 32'h0;
    cfg_write(32'h0, 32'h5);
    @(negedge clk);
    config_data = 32'hDEAD_BEEF;
    config_en   = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    cfg_m = 32'h0;
    chk("mid_reset.rd_now", rd_a, 32'h0);
    @(posedge clk);
    #1;
    check_all("mid_reset");
    config_en = 1'b0;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
